// File: rtl/rf_pkg.sv
// Shared write-back definitions for the register-file datapath.
// Port indices, default widths and the buffered entry layout.
package rf_pkg;

  localparam int RF_WORD_WIDTH    = 16;
  localparam int RF_ADDRESS_WIDTH = 4;
  localparam int WB_PORTS         = 4;

  typedef enum logic [1:0] {
    WB_ARITH  = 2'd0,
    WB_LOGIC  = 2'd1,
    WB_SHIFT0 = 2'd2,
    WB_SHIFT1 = 2'd3
  } wb_port_e;

  typedef struct packed {
    logic [RF_ADDRESS_WIDTH-1:0] addr;
    logic [RF_WORD_WIDTH-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One buffered write-back result with its pending flag.
// A load wins over a retire in the same cycle (refill).
module rf_wb_slot #(
  parameter int AW = 4,
  parameter int WW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          retire,
  input  logic [AW-1:0] addr_in,
  input  logic [WW-1:0] data_in,
  output logic          pend,
  output logic [AW-1:0] addr,
  output logic [WW-1:0] data
);

  // hold the entry until it is granted; refill replaces it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      pend <= 1'b1;
      addr <= addr_in;
      data <= data_in;
    end else if (retire) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/tree_decoder.sv
// Binary select to one-hot line decoder.
// Used for per-slot GPR scoreboard bits.
module tree_decoder #(
  parameter int AW = 4
) (
  input  logic [AW-1:0]      sel,
  output logic [2**AW-1:0]   onehot
);

  // one line high for the selected index
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back scheduler for the four RF write ports.
// Same-GPR writes retire oldest first; exports a busy scoreboard.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int WORD_WIDTH    = RF_WORD_WIDTH,
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  localparam int UNITS        = 2**ADDRESS_WIDTH,
  localparam int PORTS        = 4
) (
  input  logic                                clk_i,
  input  logic                                arst_n_i,
  input  logic [PORTS-1:0]                    res_valid_i,
  output logic [PORTS-1:0]                    res_ready_o,
  input  logic [PORTS-1:0][ADDRESS_WIDTH-1:0] res_addr_i,
  input  logic [PORTS-1:0][WORD_WIDTH-1:0]    res_data_i,
  output logic [PORTS-1:0][ADDRESS_WIDTH-1:0] select_r_o,
  output logic [PORTS-1:0][WORD_WIDTH-1:0]    data_o,
  output logic [PORTS-1:0]                    enable_writing_o,
  output logic [UNITS-1:0]                    busy_o,
  output logic                                idle_o
);

  logic [PORTS-1:0]                    pend;
  logic [PORTS-1:0]                    grant;
  logic [PORTS-1:0]                    acc;
  logic [PORTS-1:0]                    stay;
  logic [PORTS-1:0][ADDRESS_WIDTH-1:0] addr;
  logic [PORTS-1:0][WORD_WIDTH-1:0]    data;
  logic [PORTS-1:0][PORTS-1:0]         older;
  logic [PORTS-1:0][PORTS-1:0]         older_n;
  logic [PORTS-1:0][UNITS-1:0]         hit;

  for (genvar p = 0; p < PORTS; p++) begin : g_slot
    rf_wb_slot #(
      .AW(ADDRESS_WIDTH),
      .WW(WORD_WIDTH)
    ) u_slot (
      .clk    (clk_i),
      .rst_n  (arst_n_i),
      .load   (acc[p]),
      .retire (grant[p]),
      .addr_in(res_addr_i[p]),
      .data_in(res_data_i[p]),
      .pend   (pend[p]),
      .addr   (addr[p]),
      .data   (data[p])
    );

    tree_decoder #(
      .AW(ADDRESS_WIDTH)
    ) u_dec (
      .sel   (addr[p]),
      .onehot(hit[p])
    );
  end

  // a slot writes unless an older slot targets the same GPR
  always_comb begin
    grant = '0;
    for (int p = 0; p < PORTS; p++) begin
      grant[p] = pend[p];
      for (int q = 0; q < PORTS; q++) begin
        if (q != p && pend[q] && older[q][p] &&
            addr[q] == addr[p])
          grant[p] = 1'b0;
      end
    end
  end

  assign res_ready_o      = ~pend | grant;
  assign acc              = res_valid_i & res_ready_o;
  assign stay             = pend & ~grant;
  assign enable_writing_o = grant;
  assign select_r_o       = addr;
  assign data_o           = data;
  assign idle_o           = ~|pend;

  // new entries are younger than survivors; lower index wins ties
  always_comb begin
    older_n = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = 0; q < PORTS; q++) begin
        if (p != q) begin
          if (acc[p] && acc[q])
            older_n[p][q] = (p < q);
          else if (acc[p])
            older_n[p][q] = 1'b0;
          else if (acc[q])
            older_n[p][q] = stay[p];
          else
            older_n[p][q] = older[p][q] & stay[p] & stay[q];
        end
      end
    end
  end

  // age matrix register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)
      older <= '0;
    else
      older <= older_n;
  end

  // pending-write scoreboard, granting slots included
  always_comb begin
    busy_o = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (pend[p])
        busy_o = busy_o | hit[p];
    end
  end

endmodule
